// File: rtl/multdiv_scheduler.sv
// multdiv_scheduler: shares a single multdiv unit between two requesters
// (r0, r1). Round-robin arbitration, one operation in flight at a time.
// The scheduler drives the unit's ctrl_MULT/ctrl_DIV handshake, latches the
// result and exception, and returns them to the owning requester with
// valid/ready backpressure.
// Optional build macro: MDS_TIMEOUT_EN adds a watchdog over ISSUE+BUSY that
// forces a response with result 0 and the exception bit set.
module multdiv_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 80
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_op,
  input  logic        r1_op,
  input  logic [31:0] r0_opA,
  input  logic [31:0] r1_opA,
  input  logic [15:0] r0_opB,
  input  logic [15:0] r1_opB,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_exception,
  output logic [31:0] md_operandA,
  output logic [15:0] md_operandB,
  output logic        md_MULT,
  output logic        md_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_inputRDY,
  input  logic        md_resultRDY,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        op_q;
  logic [31:0] a_q;
  logic [15:0] b_q;
  logic        last_owner;
  logic        owner_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        grant_any;
  logic        grant_idx;
  logic        result_take;
  logic        rsp_fire;
  logic        tmo_hit;

  assign grant_any   = r0_gnt | r1_gnt;
  assign grant_idx   = r1_gnt;
  assign result_take = (state == BUSY) && md_resultRDY;
  assign rsp_fire    = (state == RESP) && rsp_ready[owner_q];

`ifdef MDS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = ((state == ISSUE) || (state == BUSY)) &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared on the grant edge (entry to ISSUE), counts ISSUE+BUSY cycles
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      tmo_cnt <= '0;
    end else if (grant_any) begin
      tmo_cnt <= '0;
    end else if ((state == ISSUE) || (state == BUSY)) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Round-robin grant, only offered while IDLE; a tie goes to !last_owner
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (state == IDLE) begin
      if (r0_req && (!r1_req || last_owner)) r0_gnt = 1'b1;
      else if (r1_req)                       r1_gnt = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; a real result arriving on the timeout cycle wins
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_any)    state_nxt = ISSUE;
      ISSUE:   if (md_inputRDY)  state_nxt = BUSY;
      BUSY:    if (md_resultRDY) state_nxt = RESP;
      RESP:    if (rsp_fire)     state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
    if (tmo_hit && !result_take) state_nxt = RESP;
  end

  // Output decode: unit controls only in ISSUE/BUSY, response only in RESP
  always_comb begin
    md_MULT       = 1'b0;
    md_DIV        = 1'b0;
    rsp_valid     = '0;
    busy          = (state != IDLE);
    md_operandA   = a_q;
    md_operandB   = b_q;
    rsp_result    = result_q;
    rsp_exception = exc_q;
    owner         = owner_q;
    unique case (state)
      ISSUE, BUSY: begin
        md_MULT = ~op_q;
        md_DIV  = op_q;
      end
      RESP:    rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  // Operand/ownership capture on grant, result capture on resultRDY or timeout
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      last_owner <= 1'b1;
      owner_q    <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      if (grant_any) begin
        op_q       <= grant_idx ? r1_op  : r0_op;
        a_q        <= grant_idx ? r1_opA : r0_opA;
        b_q        <= grant_idx ? r1_opB : r0_opB;
        last_owner <= grant_idx;
        owner_q    <= grant_idx;
      end
      if (result_take) begin
        result_q <= md_result;
        exc_q    <= md_exception | (op_q & (b_q == '0));
      end else if (tmo_hit) begin
        result_q <= '0;
        exc_q    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Testbench for multdiv_scheduler: directed scenarios followed by randomized
// dual-requester traffic. Grants, ownership and responses are predicted by a
// transaction-level model; expected responses are queued on predicted grant
// and compared by a monitor whenever the DUT presents rsp_valid.
module tb_multdiv_scheduler;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic        r0_op = 1'b0, r1_op = 1'b0;
  logic [31:0] r0_opA = '0, r1_opA = '0;
  logic [15:0] r0_opB = '0, r1_opB = '0;
  logic        r0_gnt, r1_gnt;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_result;
  logic        rsp_exception;
  logic [31:0] md_operandA;
  logic [15:0] md_operandB;
  logic        md_MULT, md_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_inputRDY, md_resultRDY;
  logic        busy, owner;

  multdiv_scheduler #(.TIMEOUT_CYCLES(80)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .r0_req(r0_req), .r1_req(r1_req), .r0_op(r0_op), .r1_op(r1_op),
    .r0_opA(r0_opA), .r1_opA(r1_opA), .r0_opB(r0_opB), .r1_opB(r1_opB),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_exception(rsp_exception),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_MULT(md_MULT), .md_DIV(md_DIV),
    .md_result(md_result), .md_exception(md_exception),
    .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural unit arithmetic: {overflow, low 32 bits}; divide by zero gives 0, no flag
  function automatic logic [32:0] unit_math(input logic op, input logic [31:0] a, input logic [15:0] b);
    longint sa, sb, r;
    logic [31:0] lo;
    sa = $signed(a);
    sb = $signed(b);
    if (!op)          r = sa * sb;
    else if (sb == 0) r = 0;
    else              r = sa / sb;
    lo = r[31:0];
    return {(r != longint'($signed(lo))), lo};
  endfunction

  // ---------------- multdiv unit model ----------------
  bit hang = 0;
  bit slow = 0;
  int ucnt = 0, d_in = 0, d_res = 1;

  always @(posedge clock or negedge ctrl_reset) begin
    int t;
    if (!ctrl_reset) ucnt <= 0;
    else if (md_MULT | md_DIV) ucnt <= ucnt + 1;
    else begin
      t = slow ? 0 : int'($urandom_range(0, 3));
      ucnt  <= 0;
      d_in  <= t;
      d_res <= slow ? 20 : t + 1 + int'($urandom_range(0, 4));
    end
  end

  assign md_inputRDY  = (md_MULT | md_DIV) && (ucnt >= d_in);
  assign md_resultRDY = !hang && (md_MULT | md_DIV) && (ucnt >= d_res);
  assign {md_exception, md_result} = unit_math(md_DIV, md_operandA, md_operandB);

  // ---------------- response ready driver ----------------
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      1:       rsp_ready = 2'b11;
      default: rsp_ready = 2'b00;
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic        own;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t        q[$];
  bit          mon_en = 0;
  bit          inflight = 0;
  logic        m_last = 1'b1;
  logic        m_owner = 1'b0;
  logic [1:0]  eg;
  exp_t        e;
  logic [32:0] um;
  logic        s_op;
  logic [31:0] s_a;
  logic [15:0] s_b;

  always @(negedge clock) begin
    if (!ctrl_reset) begin
      q.delete();
      inflight = 0;
      m_last   = 1'b1;
      m_owner  = 1'b0;
    end else if (mon_en) begin
      chk("busy", busy, inflight);
      chk("owner", owner, m_owner);
      eg = 2'b00;
      if (!inflight) begin
        if (r0_req && (!r1_req || m_last)) eg = 2'b01;
        else if (r1_req)                   eg = 2'b10;
      end
      if (r0_req | r1_req | r0_gnt | r1_gnt) chk("gnt", {r1_gnt, r0_gnt}, eg);
      if (eg != 2'b00) begin
        s_op  = eg[1] ? r1_op  : r0_op;
        s_a   = eg[1] ? r1_opA : r0_opA;
        s_b   = eg[1] ? r1_opB : r0_opB;
        um    = unit_math(s_op, s_a, s_b);
        e.own = eg[1];
        e.res = hang ? 32'd0 : um[31:0];
        e.exc = hang ? 1'b1 : (um[32] | (s_op && (s_b == 16'd0)));
        q.push_back(e);
        inflight = 1;
        m_last   = eg[1];
        m_owner  = eg[1];
      end
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp_valid", rsp_valid, 2'b00);
        end else begin
          chk("rsp_valid", rsp_valid, q[0].own ? 2'b10 : 2'b01);
          chk("rsp_result", rsp_result, q[0].res);
          chk("rsp_exception", rsp_exception, q[0].exc);
          chk("md_ctrl_in_resp", {md_MULT, md_DIV}, 2'b00);
          if ((rsp_valid & rsp_ready) != 2'b00) begin
            void'(q.pop_front());
            inflight = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input int idx, input logic op, input logic [31:0] a,
                           input logic [15:0] b, input int max_wait, output bit granted);
    granted = 0;
    if (idx == 0) begin r0_op = op; r0_opA = a; r0_opB = b; r0_req = 1'b1; end
    else          begin r1_op = op; r1_opA = a; r1_opB = b; r1_req = 1'b1; end
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clock);
      if (((idx == 0) ? r0_gnt : r1_gnt) && ctrl_reset) begin
        granted = 1;
        break;
      end
    end
    @(posedge clock);
    #1;
    if (idx == 0) r0_req = 1'b0;
    else          r1_req = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((inflight || q.size() != 0) && n < max) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("drain", (inflight || q.size() != 0), 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3 ctrl_reset = 1'b0;
    #1;
    chk("rst_gnt", {r1_gnt, r0_gnt}, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_md_ctrl", {md_MULT, md_DIV}, 2'b00);
    chk("rst_md_operandA", md_operandA, 32'd0);
    chk("rst_md_operandB", md_operandB, 16'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_exception", rsp_exception, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    repeat (2) @(posedge clock);
    #3 ctrl_reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_a();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 200)) - 32'd100;
      1:       return $urandom;
      2:       return 32'h8000_0000;
      default: return 32'($urandom_range(0, 70000));
    endcase
  endfunction

  function automatic logic [15:0] rand_b();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'($urandom_range(0, 20)) - 16'd10;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_reqs(input int idx, input int n);
    bit g;
    int mw;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 400;
      drive_req(idx, 1'($urandom_range(0, 1)), rand_a(), rand_b(), mw, g);
      if (mw == 400) chk("rand_gnt", g, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit g, g0, g1;
    int k;

    do_reset();
    mon_en = 1;

    // r0 MULT 7 * -3
    rdy_mode = 1;
    drive_req(0, 1'b0, 32'd7, 16'hFFFD, 20, g);
    chk("t1_gnt", g, 1'b1);
    chk("t1_md_ctrl", {md_MULT, md_DIV}, 2'b10);
    chk("t1_md_operandA", md_operandA, 32'd7);
    chk("t1_md_operandB", md_operandB, 16'hFFFD);
    wait_idle(100);

    // Simultaneous requests straight after reset: r0 first, then r1, next tie r0
    do_reset();
    @(posedge clock); #1;
    fork
      drive_req(0, 1'b1, 32'd100, 16'd7, 100, g0);
      drive_req(1, 1'b0, 32'd6, 16'd5, 100, g1);
    join
    chk("tie_r0_gnt", g0, 1'b1);
    chk("tie_r1_gnt", g1, 1'b1);
    fork
      drive_req(0, 1'b0, 32'd3, 16'd4, 100, g0);
      drive_req(1, 1'b0, 32'd8, 16'd9, 100, g1);
    join
    wait_idle(100);

    // r1 divide by zero: exception flagged although unit reports none
    drive_req(1, 1'b1, 32'd1234, 16'd0, 20, g);
    chk("div0_gnt", g, 1'b1);
    wait_idle(100);

    // Response backpressure for 5 cycles; a waiting r1 must not be granted
    rdy_mode = 2;
    drive_req(0, 1'b0, 32'd123, 16'd45, 20, g);
    k = 0;
    while (rsp_valid == 2'b00 && k < 50) begin @(negedge clock); k++; end
    chk("bp_valid_seen", rsp_valid, 2'b01);
    @(posedge clock); #1;
    fork
      begin
        bit gb;
        drive_req(1, 1'b0, 32'd9, 16'd9, 100, gb);
        chk("bp_r1_gnt", gb, 1'b1);
      end
    join_none
    repeat (5) begin
      @(negedge clock);
      chk("bp_no_gnt", r1_gnt, 1'b0);
      chk("bp_valid_held", rsp_valid, 2'b01);
    end
    rdy_mode = 1;
    wait fork;
    wait_idle(100);

    // Reset while the unit is busy
    slow = 1;
    drive_req(0, 1'b1, 32'd5000, 16'd7, 20, g);
    chk("rb_div_issue", md_DIV, 1'b1);
    do_reset();
    slow = 0;
    @(posedge clock); #1;
    drive_req(1, 1'b0, 32'd11, 16'hFFFE, 20, g);
    chk("post_reset_gnt", g, 1'b1);
    wait_idle(100);

`ifdef MDS_TIMEOUT_EN
    // Unit never finishes: watchdog response after 80 cycles in ISSUE+BUSY
    hang = 1;
    drive_req(0, 1'b0, 32'd5, 16'd5, 20, g);
    k = 1;
    @(negedge clock);
    while (rsp_valid == 2'b00 && k < 200) begin @(negedge clock); k++; end
    chk("timeout_latency", k, 81);
    wait_idle(50);
    hang = 0;
`endif

    // Randomized dual-requester traffic with random response backpressure
    rdy_mode = 0;
    fork
      rand_reqs(0, 40);
      rand_reqs(1, 40);
    join
    rdy_mode = 1;
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multdiv_scheduler.md
Name: multdiv_scheduler

Overview:
- Arbiter and sequencer that shares one multdiv unit between two requesters, r0 and r1. Typical requesters are the pipeline execute port and a debug/microcode port.
- Round-robin grant; exactly one operation is in flight at a time.
- Drives the unit's ctrl_MULT/ctrl_DIV handshake, latches the result and exception, and returns them to the owning requester with valid/ready backpressure.

Parameters:
- TIMEOUT_CYCLES, 80, watchdog limit in clock cycles for ISSUE+BUSY (used only with MDS_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge
- ctrl_reset  in  1  asynchronous, active-low reset
- r0_req, r1_req  in  1  request; held with stable op/operands until gnt
- r0_op, r1_op  in  1  0=MULT, 1=DIV
- r0_opA, r1_opA  in  32  signed operand A
- r0_opB, r1_opB  in  16  signed operand B
- r0_gnt, r1_gnt  out  1  one-cycle accept pulse; operands latched at this edge
- rsp_valid  out  2  one-hot response owner (bit0=r0, bit1=r1)
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  32  latched result
- rsp_exception  out  1  latched exception
- md_operandA  out  32  to unit data_operandA
- md_operandB  out  16  to unit data_operandB
- md_MULT, md_DIV  out  1  to unit ctrl_MULT/ctrl_DIV
- md_result  in  32  from unit data_result
- md_exception  in  1  from unit data_exception
- md_inputRDY, md_resultRDY  in  1  from unit
- busy  out  1  high in any state except IDLE
- owner  out  1  current/last owner index

Behaviour:
- Reset (ctrl_reset=0, async): state=IDLE.
  - All outputs 0: gnt, rsp_valid, md_MULT, md_DIV, md_operandA/B, rsp_result, rsp_exception, busy.
  - last_owner=1, so r0 wins the first tie; owner=0.
- IDLE:
  - If any req is high, assert gnt combinationally to one requester.
  - Single requester: grant it.
  - Both requesting: grant !last_owner.
  - On that edge, latch op/opA/opB into op_q/a_q/b_q; owner=last_owner=granted index; go to ISSUE.
  - No req: stay.
- ISSUE:
  - md_operandA=a_q, md_operandB=b_q; md_MULT=~op_q, md_DIV=op_q, all held stable.
  - On md_inputRDY sampled high, go to BUSY. md_resultRDY is ignored in ISSUE.
- BUSY:
  - Control and operands stay held.
  - On md_resultRDY sampled high:
    - rsp_result<=md_result.
    - rsp_exception<=md_exception | (op_q & (b_q==0)).
    - Go to RESP.
- RESP:
  - md_MULT=md_DIV=0, giving a ≥1-cycle low gap before the next op.
  - rsp_valid[owner]=1; result and exception held stable.
  - On rsp_ready[owner]=1, go to IDLE; rsp_valid drops the next cycle.
  - rsp_ready of the non-owner is ignored.
- No requests are granted outside IDLE; requests arriving during an operation wait.
- Minimum latency: gnt edge T → ISSUE at T+1; if md_inputRDY is already high, BUSY at T+2; result cycle R → rsp_valid at R+1.
- Back-to-back: after rsp accept, IDLE for one cycle, then the next grant can occur. Round robin alternates under continuous dual requests.
- Req deasserted before gnt: no grant; the request is not remembered.
- Reset mid-operation: returns immediately to IDLE; any pending response is discarded; md_ controls low asynchronously.

Optional Feature:
- Macro MDS_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ISSUE and counts in ISSUE and BUSY.
  - When it reaches TIMEOUT_CYCLES, go to RESP with rsp_result=0 and rsp_exception=1.
  - md controls drop in RESP. A late md_resultRDY is ignored until the next ISSUE.
- Undefined: no counter; the scheduler waits indefinitely in ISSUE/BUSY.

Test Plan:
- r0 MULT opA=7 opB=-3, rsp_ready=1 → r0_gnt pulse; md_MULT high until resultRDY; rsp_valid=01, rsp_result=-21, rsp_exception=0.
- r0 and r1 request the same cycle after reset: r0 DIV 100/7, r1 MULT 6*5 → r0 granted first; r0 gets 14, then r1 gets 30; next tie is granted to r0.
- r1 DIV opA=1234 opB=0 → rsp_valid=10, rsp_exception=1 even if the unit model reports exception=0.
- rsp_ready held low 5 cycles in RESP → rsp_valid and rsp_result stable for all 5 cycles; md_MULT/md_DIV low; no new gnt until accept.
- ctrl_reset pulsed low during BUSY → md_DIV=0 and busy=0 immediately; no rsp_valid; next request is granted normally.
- With MDS_TIMEOUT_EN and TIMEOUT_CYCLES=80, unit model never asserts resultRDY → rsp_valid after 80 cycles in ISSUE+BUSY, rsp_result=0, rsp_exception=1.
